// File: rtl/fft_pkg.sv
// Shared definitions for the voice FFT pipeline: widths, twiddle constants,
// butterfly phase encoding and the sum/difference scaling helper.
package fft_pkg;

  localparam int DW = 33;
  localparam int TW = 2;

  typedef struct packed {
    logic signed [TW-1:0] re;
    logic signed [TW-1:0] im;
  } tw_t;

  localparam tw_t W_ONE = '{re: 2'sb01, im: 2'sb00};
  localparam tw_t W_MJ  = '{re: 2'sb00, im: 2'sb11};

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_BFLY = 1'b1
  } phase_e;

  // x is the full-precision (DW+1)-bit sum/difference; either halve it or wrap it.
  function automatic logic [DW-1:0] bf_scale(input logic [DW:0] x, input logic scale);
    return scale ? x[DW:1] : x[DW-1:0];
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback FIFO of the SDF stage: a DELAY-deep shift register that advances
// (pops head, pushes new word) only when enabled.
module sdf_delay_line #(
  parameter int DELAY = 2,
  parameter int W     = 66
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic [W-1:0] push_i,
  output logic [W-1:0] head_o
);

  // Contents are never reset; the butterfly masks them until primed.
  logic [W-1:0] mem_q [DELAY];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[0] <= push_i;
      for (int i = 1; i < DELAY; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign head_o = mem_q[DELAY-1];

endmodule

// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly: streams sums then differences
// of each 2*DELAY frame, tagged with the trivial twiddle (+1 or -j) for the next stage.
module sdf_butterfly
  import fft_pkg::*;
#(
  parameter int DELAY = 2,
  parameter int SCALE = 1
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 IN_VALID,
  input  logic signed [DW-1:0] IN_RE,
  input  logic signed [DW-1:0] IN_IM,
  output logic                 OUT_VALID,
  output logic signed [DW-1:0] OUT_RE,
  output logic signed [DW-1:0] OUT_IM,
  output logic signed [TW-1:0] W_RE,
  output logic signed [TW-1:0] W_IM
);

  localparam int             CW   = $clog2(2*DELAY);
  localparam logic [CW-1:0]  HALF = CW'(DELAY/2);
  localparam logic           SCL  = (SCALE != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          primed_q, primed_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] re_q, re_d, im_q, im_d;
  tw_t           w_q, w_d;

  logic [2*DW-1:0] head, push;
  logic [DW-1:0]   hd_re, hd_im;
  logic [DW:0]     sum_re, sum_im, dif_re, dif_im;
  phase_e          phase;

  assign phase = phase_e'(cnt_q[CW-1]);
  assign hd_re = head[2*DW-1:DW];
  assign hd_im = head[DW-1:0];

  assign sum_re = {hd_re[DW-1], hd_re} + {IN_RE[DW-1], IN_RE};
  assign sum_im = {hd_im[DW-1], hd_im} + {IN_IM[DW-1], IN_IM};
  assign dif_re = {hd_re[DW-1], hd_re} - {IN_RE[DW-1], IN_RE};
  assign dif_im = {hd_im[DW-1], hd_im} - {IN_IM[DW-1], IN_IM};

  // Fill phase stores raw input; butterfly phase feeds back the difference.
  assign push = (phase == PH_BFLY) ? {bf_scale(dif_re, SCL), bf_scale(dif_im, SCL)}
                                   : {IN_RE, IN_IM};

  sdf_delay_line #(
    .DELAY (DELAY),
    .W     (2*DW)
  ) u_dl (
    .clk_i  (CLK),
    .en_i   (IN_VALID),
    .push_i (push),
    .head_o (head)
  );

  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    vld_d    = 1'b0;
    re_d     = re_q;
    im_d     = im_q;
    w_d      = w_q;
    if (IN_VALID) begin
      cnt_d = cnt_q + CW'(1);
      if (phase == PH_FILL) begin
        re_d  = hd_re;
        im_d  = hd_im;
        w_d   = (cnt_q < HALF) ? W_ONE : W_MJ;
        vld_d = primed_q;
      end else begin
        re_d     = bf_scale(sum_re, SCL);
        im_d     = bf_scale(sum_im, SCL);
        w_d      = W_ONE;
        vld_d    = 1'b1;
        primed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
      vld_q    <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      w_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      vld_q    <= vld_d;
      re_q     <= re_d;
      im_q     <= im_d;
      w_q      <= w_d;
    end
  end

  assign OUT_VALID = vld_q;
  assign OUT_RE    = re_q;
  assign OUT_IM    = im_q;
  assign W_RE      = w_q.re;
  assign W_IM      = w_q.im;

endmodule
